// File: rtl/bec_la_pkg.sv
// rtl/bec_la_pkg.sv - shared codes, state encoding and LA field positions for the operand bridge
package bec_la_pkg;

   localparam logic [7:0] MAGIC       = 8'hAB;

   localparam logic [7:0] OP_WRITE    = 8'h40;
   localparam logic [7:0] OP_START    = 8'h41;
   localparam logic [7:0] OP_READ     = 8'h42;
   localparam logic [7:0] OP_CLEAR    = 8'h43;

   localparam logic [7:0] ERR_NONE    = 8'h00;
   localparam logic [7:0] ERR_TIMEOUT = 8'h02;
   localparam logic [7:0] ERR_MAGIC   = 8'h03;
   localparam logic [7:0] ERR_IDX     = 8'h04;
   localparam logic [7:0] ERR_OP      = 8'h05;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_BUSY = 2'b10
   } state_t;

   localparam int LA_TOG      = 127;
   localparam int LA_PAY_LO   = 32;
   localparam int LA_PAY_W    = 82;
   localparam int LA_MAGIC_LO = 24;
   localparam int LA_OP_LO    = 16;
   localparam int LA_REG_LO   = 8;
   localparam int LA_CHK_LO   = 0;

   // Magic is checked first, then the opcode, then the indices the opcode actually uses.
   function automatic logic [7:0] cmd_err(input logic [7:0] magic, input logic [7:0] op,
                                          input logic [7:0] ridx, input logic [7:0] cidx,
                                          input int nregs, input int nres, input int nchunk);
      logic [7:0] e;
      e = ERR_NONE;
      if (magic != MAGIC) begin
         e = ERR_MAGIC;
      end else begin
         case (op)
            OP_WRITE: if (int'(ridx) >= nregs || int'(cidx) >= nchunk) e = ERR_IDX;
            OP_READ:  if (int'(ridx) >= nregs + nres || int'(cidx) >= nchunk) e = ERR_IDX;
            OP_START, OP_CLEAR: e = ERR_NONE;
            default:  e = ERR_OP;
         endcase
      end
      return e;
   endfunction

endpackage

// File: rtl/bec_op_timer.sv
// rtl/bec_op_timer.sv - watchdog counter with clear, enable and expire flag
module bec_op_timer #(
   parameter int LIMIT = 65535
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] r_cnt;

   // Holds at LIMIT-1 so an unserviced expire never wraps back to zero.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expire) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expire = (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/bec_la_operand_bridge.sv
// rtl/bec_la_operand_bridge.sv - LA-bus operand loader, core launcher and result reader
module bec_la_operand_bridge
   import bec_la_pkg::*;
#(
   parameter int WIDTH   = 163,
   parameter int NREGS   = 7,
   parameter int NRES    = 2,
   parameter int CHUNK   = 82,
   parameter int TIMEOUT = 65535
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic [127:0]           la_data_in,
   input  logic [127:0]           la_oenb,
   output logic [127:0]           la_data_out,
   output logic [NREGS*WIDTH-1:0] op_flat,
   input  logic [NRES*WIDTH-1:0]  res_flat,
   output logic                   core_start,
   input  logic                   core_done,
   output logic                   busy
);

   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int PADW   = NCHUNK * CHUNK;

   state_t           r_state;
   logic             r_last_tog;
   logic             r_ack_tog;
   logic             r_done;
   logic [7:0]       r_err;
   logic [CHUNK-1:0] r_rdata;
   logic             r_core_start;
   logic [7:0]       r_cmd_magic;
   logic [7:0]       r_cmd_op;
   logic [7:0]       r_cmd_reg;
   logic [7:0]       r_cmd_chk;
   logic [CHUNK-1:0] r_cmd_pay;
   logic [WIDTH-1:0] r_opnd [NREGS];
   logic [WIDTH-1:0] r_res  [NRES];

   logic [7:0]       w_in_magic, w_in_op, w_in_reg, w_in_chk;
   logic [7:0]       w_in_err, w_err;
   logic             w_new_req;
   logic             w_expire;
   logic [WIDTH-1:0] w_sel;
   logic [PADW-1:0]  w_sel_pad;
   logic [CHUNK-1:0] w_rd_slice [NCHUNK];
   logic [WIDTH-1:0] w_wr_val   [NCHUNK];
   logic [WIDTH-1:0] w_wr_mask  [NCHUNK];
   logic [CHUNK-1:0] w_rd_sel;
   logic [WIDTH-1:0] w_cw_val, w_cw_mask;
   logic             w_unused;

   assign w_in_magic = la_data_in[LA_MAGIC_LO +: 8];
   assign w_in_op    = la_data_in[LA_OP_LO +: 8];
   assign w_in_reg   = la_data_in[LA_REG_LO +: 8];
   assign w_in_chk   = la_data_in[LA_CHK_LO +: 8];
   assign w_new_req  = (la_data_in[LA_TOG] != r_last_tog) & ~la_oenb[LA_TOG];
   assign w_in_err   = cmd_err(w_in_magic, w_in_op, w_in_reg, w_in_chk, NREGS, NRES, NCHUNK);
   assign w_err      = cmd_err(r_cmd_magic, r_cmd_op, r_cmd_reg, r_cmd_chk, NREGS, NRES, NCHUNK);
   assign w_unused   = ^{la_oenb[126:0], la_data_in[126:LA_PAY_LO]};

   bec_op_timer #(.LIMIT(TIMEOUT)) u_timer (
      .i_clk    (wb_clk_i),
      .i_rst    (wb_rst_i),
      .i_clr    (r_state == ST_EXEC),
      .i_en     (r_state == ST_BUSY),
      .o_expire (w_expire)
   );

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NREGS; i++)
         if (r_cmd_reg == 8'(i)) w_sel = r_opnd[i];
      for (int j = 0; j < NRES; j++)
         if (r_cmd_reg == 8'(NREGS + j)) w_sel = r_res[j];
   end

   // Padding to a whole number of chunks gives zero-fill on read and discard on write for free.
   assign w_sel_pad = PADW'(w_sel);

   for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
      assign w_rd_slice[k] = w_sel_pad[k*CHUNK +: CHUNK];
      assign w_wr_val[k]   = WIDTH'(PADW'(r_cmd_pay) << (k*CHUNK));
      assign w_wr_mask[k]  = WIDTH'(PADW'({CHUNK{1'b1}}) << (k*CHUNK));
   end

   always_comb begin
      w_rd_sel  = '0;
      w_cw_val  = '0;
      w_cw_mask = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (r_cmd_chk == 8'(k)) begin
            w_rd_sel  = w_rd_slice[k];
            w_cw_val  = w_wr_val[k];
            w_cw_mask = w_wr_mask[k];
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state      <= ST_IDLE;
         r_last_tog   <= 1'b0;
         r_ack_tog    <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= ERR_NONE;
         r_rdata      <= '0;
         r_core_start <= 1'b0;
         r_cmd_magic  <= '0;
         r_cmd_op     <= '0;
         r_cmd_reg    <= '0;
         r_cmd_chk    <= '0;
         r_cmd_pay    <= '0;
         for (int i = 0; i < NREGS; i++) r_opnd[i] <= '0;
         for (int j = 0; j < NRES; j++)  r_res[j]  <= '0;
      end else begin
         r_core_start <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_new_req) begin
                  r_cmd_magic  <= w_in_magic;
                  r_cmd_op     <= w_in_op;
                  r_cmd_reg    <= w_in_reg;
                  r_cmd_chk    <= w_in_chk;
                  r_cmd_pay    <= la_data_in[LA_PAY_LO +: CHUNK];
                  r_last_tog   <= la_data_in[LA_TOG];
                  // Registered here so the pulse coincides exactly with the EXEC cycle.
                  r_core_start <= (w_in_op == OP_START) && (w_in_err == ERR_NONE);
                  r_state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_ack_tog <= r_last_tog;
               r_err     <= w_err;
               r_state   <= ST_IDLE;
               if (w_err == ERR_NONE) begin
                  case (r_cmd_op)
                     OP_WRITE: begin
                        for (int i = 0; i < NREGS; i++)
                           if (r_cmd_reg == 8'(i))
                              r_opnd[i] <= (r_opnd[i] & ~w_cw_mask) | w_cw_val;
                     end
                     OP_START: begin
                        r_done  <= 1'b0;
                        r_state <= ST_BUSY;
                     end
                     OP_READ: r_rdata <= w_rd_sel;
                     OP_CLEAR: begin
                        for (int i = 0; i < NREGS; i++) r_opnd[i] <= '0;
                        for (int j = 0; j < NRES; j++)  r_res[j]  <= '0;
                        r_done <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               if (core_done) begin
                  for (int j = 0; j < NRES; j++) r_res[j] <= res_flat[j*WIDTH +: WIDTH];
                  r_done  <= 1'b1;
                  r_err   <= ERR_NONE;
                  r_state <= ST_IDLE;
               end else if (w_expire) begin
                  r_err   <= ERR_TIMEOUT;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NREGS; i++) begin : g_opflat
      assign op_flat[i*WIDTH +: WIDTH] = r_opnd[i];
   end

   assign la_data_out = {r_ack_tog, r_state, r_done, r_err, 2'b00, LA_PAY_W'(r_rdata), 32'h0};
   assign core_start  = r_core_start;
   assign busy        = (r_state == ST_BUSY);

endmodule
